mag_approx_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one magnitude-approximation engine (complex in, unsigned magnitude out, AXI-stream, any fixed latency) between NUM_CH complex sample streams. It grants one input channel per packet, records each grant in an in-order tag FIFO, and routes engine results back to the matching output channel. It sits between the per-channel sample sources and a single shared engine instance, and adds no registers to the data path.

---
 rtl/mag_arb_pkg.sv | 40 ++++
 rtl/mag_arb_tag_fifo.sv | 53 +++++
 rtl/mag_approx_arbiter.sv | 124 ++++++++++++
 tb/tb_mag_approx_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mag_arb_pkg.sv
// Shared types and helpers for the magnitude-engine arbiter and its tag FIFO.
package mag_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_CH = 16;
    localparam int unsigned CH_W   = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // First requester strictly after last, wrapping modulo num_ch; last itself is checked last.
    function automatic logic [CH_W-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                input logic [CH_W-1:0] last,
                                                input int unsigned num_ch);
        logic [CH_W-1:0] pick;
        logic            found;
        int unsigned     idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            idx = (32'(last) + k) % num_ch;
            if (k <= num_ch && !found && req[idx[CH_W-1:0]]) begin
                pick  = idx[CH_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mag_arb_tag_fifo.sv
// In-order FIFO of granted channel numbers; the head steers engine results to their lane.
module mag_arb_tag_fifo
    import mag_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/mag_approx_arbiter.sv
// Packet-granular round-robin share of one magnitude engine between NUM_CH complex streams.
module mag_approx_arbiter
    import mag_arb_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clear,
    input  logic [NUM_CH*2*WIDTH-1:0]     i_tdata,
    input  logic [NUM_CH-1:0]             i_tlast,
    input  logic [NUM_CH-1:0]             i_tvalid,
    output logic [NUM_CH-1:0]             i_tready,
    output logic [NUM_CH*WIDTH-1:0]       o_tdata,
    output logic [NUM_CH-1:0]             o_tlast,
    output logic [NUM_CH-1:0]             o_tvalid,
    input  logic [NUM_CH-1:0]             o_tready,
    output logic [2*WIDTH-1:0]            eng_i_tdata,
    output logic                          eng_i_tlast,
    output logic                          eng_i_tvalid,
    input  logic                          eng_i_tready,
    input  logic [WIDTH-1:0]              eng_o_tdata,
    input  logic                          eng_o_tlast,
    input  logic                          eng_o_tvalid,
    output logic                          eng_o_tready,
    output logic [clog2(NUM_CH)-1:0]      grant,
    output logic                          busy
);

    localparam int unsigned GW = clog2(NUM_CH);
    localparam int unsigned DW = 2 * WIDTH;

    arb_state_e    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [GW-1:0] head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_CH - 1);
        end else if (clear) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        fifo_push    = 1'b0;
        i_tready     = '0;
        eng_i_tdata  = '0;
        eng_i_tlast  = 1'b0;
        eng_i_tvalid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|i_tvalid && !fifo_full) begin
                    grant_d   = GW'(rr_pick(MAX_CH'(i_tvalid), CH_W'(last_q), NUM_CH));
                    last_d    = grant_d;
                    fifo_push = 1'b1;
                    state_d   = ST_PASS;
                end
            end
            ST_PASS: begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    if (grant_q == GW'(c)) begin
                        eng_i_tdata  = i_tdata[c*DW +: DW];
                        eng_i_tlast  = i_tlast[c];
                        eng_i_tvalid = i_tvalid[c];
                        i_tready[c]  = eng_i_tready;
                    end
                end
                if (eng_i_tvalid && eng_i_tready && eng_i_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Results are steered purely by the oldest outstanding tag; nothing flows with an empty FIFO.
    always_comb begin
        o_tvalid     = '0;
        o_tlast      = '0;
        eng_o_tready = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!fifo_empty && head == GW'(c)) begin
                o_tvalid[c]  = eng_o_tvalid;
                o_tlast[c]   = eng_o_tlast;
                eng_o_tready = o_tready[c];
            end
        end
    end

    assign fifo_pop = eng_o_tvalid && eng_o_tready && eng_o_tlast;
    assign o_tdata  = {NUM_CH{eng_o_tdata}};
    assign grant    = grant_q;
    assign busy     = (state_q == ST_PASS);

    mag_arb_tag_fifo #(
        .WIDTH (GW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .push    (fifo_push),
        .din     (grant_d),
        .pop     (fifo_pop),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_mag_approx_arbiter.sv
// Directed bench: per-channel sources, latency-3 magnitude engine model, in-order result scoreboard.
module tb_mag_approx_arbiter;

    localparam int NCH = 4;
    localparam int W   = 16;
    localparam int TD  = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clear;
    logic [NCH*2*W-1:0] i_tdata  = '0;
    logic [NCH-1:0]   i_tlast  = '0;
    logic [NCH-1:0]   i_tvalid = '0;
    logic [NCH-1:0]   i_tready;
    logic [NCH*W-1:0] o_tdata;
    logic [NCH-1:0]   o_tlast, o_tvalid;
    logic [NCH-1:0]   o_tready;
    logic [2*W-1:0]   eng_i_tdata;
    logic             eng_i_tlast, eng_i_tvalid, eng_i_tready;
    logic [W-1:0]     eng_o_tdata;
    logic             eng_o_tlast, eng_o_tvalid, eng_o_tready;
    logic [1:0]       grant;
    logic             busy;

    mag_approx_arbiter #(
        .NUM_CH    (NCH),
        .WIDTH     (W),
        .TAG_DEPTH (TD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .i_tdata      (i_tdata),
        .i_tlast      (i_tlast),
        .i_tvalid     (i_tvalid),
        .i_tready     (i_tready),
        .o_tdata      (o_tdata),
        .o_tlast      (o_tlast),
        .o_tvalid     (o_tvalid),
        .o_tready     (o_tready),
        .eng_i_tdata  (eng_i_tdata),
        .eng_i_tlast  (eng_i_tlast),
        .eng_i_tvalid (eng_i_tvalid),
        .eng_i_tready (eng_i_tready),
        .eng_o_tdata  (eng_o_tdata),
        .eng_o_tlast  (eng_o_tlast),
        .eng_o_tvalid (eng_o_tvalid),
        .eng_o_tready (eng_o_tready),
        .grant        (grant),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // alpha=1, beta=1/4 magnitude estimate
    function automatic logic [W-1:0] mag_ref(input logic [2*W-1:0] d);
        int i, q, ai, aq, mx, mn;
        i  = int'($signed(d[2*W-1:W]));
        q  = int'($signed(d[W-1:0]));
        ai = (i < 0) ? -i : i;
        aq = (q < 0) ? -q : q;
        mx = (ai > aq) ? ai : aq;
        mn = (ai > aq) ? aq : ai;
        return W'(mx + (mn >> 2));
    endfunction

    // Engine model: stalling 3-stage pipeline, cleared together with the arbiter.
    typedef struct packed {logic v; logic [W-1:0] d; logic l;} stg_t;
    stg_t s1, s2, s3;
    logic rdy_en  = 1'b1;
    logic rnd_rdy = 1'b0;
    wire  adv = !s3.v || eng_o_tready;

    assign eng_i_tready = adv && rdy_en;
    assign eng_o_tvalid = s3.v;
    assign eng_o_tdata  = s3.d;
    assign eng_o_tlast  = s3.l;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0; s2 <= '0; s3 <= '0;
        end else if (clear) begin
            s1 <= '0; s2 <= '0; s3 <= '0;
        end else if (adv) begin
            s3 <= s2;
            s2 <= s1;
            s1 <= {eng_i_tvalid && eng_i_tready, mag_ref(eng_i_tdata), eng_i_tlast};
        end
    end

    always begin
        @(posedge clk);
        #1;
        rdy_en = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Sources: one beat queue per channel, driven 2 time units after each rising edge.
    typedef struct packed {logic [2*W-1:0] d; logic l;} beat_t;
    beat_t src_q [NCH][$];

    always begin : driver
        logic [NCH-1:0] fire;
        @(negedge clk);
        fire = i_tvalid & i_tready;
        @(posedge clk);
        #2;
        for (int c = 0; c < NCH; c++) begin
            if (fire[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
            if (src_q[c].size() > 0) begin
                i_tvalid[c]           = 1'b1;
                i_tdata[c*2*W +: 2*W] = src_q[c][0].d;
                i_tlast[c]            = src_q[c][0].l;
            end else begin
                i_tvalid[c]           = 1'b0;
                i_tdata[c*2*W +: 2*W] = '0;
                i_tlast[c]            = 1'b0;
            end
        end
    end

    // Scoreboard of expected results in return order, plus a grant-issue log.
    typedef struct packed {logic [3:0] lane; logic [W-1:0] d; logic l;} exp_t;
    exp_t sb[$];
    int   lane_cnt [NCH];
    int   glog_ch[$];
    int   glog_cyc[$];
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (|o_tvalid) check("o_tvalid_onehot", 64'($countones(o_tvalid)), 64'd1);
            for (int c = 0; c < NCH; c++) begin
                if (o_tvalid[c] && o_tready[c]) begin
                    lane_cnt[c]++;
                    if (sb.size() == 0) begin
                        check("unexpected_result_lane", 64'(c), 64'hff);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("result_lane", 64'(c), 64'(e.lane));
                        check("result_data", 64'(o_tdata[c*W +: W]), 64'(e.d));
                        check("result_last", 64'(o_tlast[c]), 64'(e.l));
                    end
                end
            end
            if (busy && !busy_prev) begin
                glog_ch.push_back(int'(grant));
                glog_cyc.push_back(cyc);
            end
        end
        busy_prev <= busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int ch, input int n, input int i, input int q);
        logic [2*W-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = {W'(i + k), W'(q)};
            src_q[ch].push_back({d, k == n - 1});
            sb.push_back({4'(ch), mag_ref(d), k == n - 1});
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) tick(1);
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_grant(input string tag, input int ch, input int budget);
        for (int k = 0; k < budget && !(busy && int'(grant) == ch); k++) tick(1);
        check(tag, {62'd0, busy, 1'b0} | 64'(grant), {62'd0, 1'b1, 1'b0} | 64'(ch));
    endtask

    task automatic clr_counts();
        for (int c = 0; c < NCH; c++) lane_cnt[c] = 0;
        glog_ch.delete();
        glog_cyc.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_grant"}, 64'(grant), 64'd0);
        check({tag, "_i_tready"}, 64'(i_tready), 64'd0);
        check({tag, "_o_tvalid"}, 64'(o_tvalid), 64'd0);
        check({tag, "_o_tlast"}, 64'(o_tlast), 64'd0);
        check({tag, "_eng_i_tvalid"}, 64'(eng_i_tvalid), 64'd0);
        check({tag, "_eng_i_tlast"}, 64'(eng_i_tlast), 64'd0);
        check({tag, "_eng_i_tdata"}, 64'(eng_i_tdata), 64'd0);
        check({tag, "_eng_o_tready"}, 64'(eng_o_tready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required summary before 200000 time units");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        clear    = 1'b0;
        o_tready = '1;
        clr_counts();
        tick(2);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        tick(2);

        // Single channel 2, four beats of (-8,4): magnitude 8 + 4/4 = 9.
        clr_counts();
        for (int k = 0; k < 4; k++) begin
            src_q[2].push_back({32'hFFF8_0004, k == 3});
            sb.push_back({4'd2, 16'd9, k == 3});
        end
        wait_drain("t1_drain", 100);
        check("t1_lane2_count", 64'(lane_cnt[2]), 64'd4);
        check("t1_other_lanes", 64'(lane_cnt[0] + lane_cnt[1] + lane_cnt[3]), 64'd0);
        check("t1_grant_count", 64'(glog_ch.size()), 64'd1);
        if (glog_ch.size() > 0) check("t1_grant_ch", 64'(glog_ch[0]), 64'd2);

        // Fresh start, all four channels request at once.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        clr_counts();
        for (int c = 0; c < NCH; c++) send_pkt(c, 1, 10 * c + 3, -(c + 2));
        wait_drain("t2_drain", 200);
        check("t2_grant_count", 64'(glog_ch.size()), 64'd4);
        if (glog_ch.size() == 4) begin
            for (int k = 0; k < 4; k++) check("t2_grant_order", 64'(glog_ch[k]), 64'(k));
            for (int k = 1; k < 4; k++)
                check("t2_grant_spacing_ge2", 64'(glog_cyc[k] - glog_cyc[k-1] >= 2), 64'd1);
        end
        for (int c = 0; c < NCH; c++) check("t2_lane_count", 64'(lane_cnt[c]), 64'd1);

        // Tag FIFO full with outputs stalled blocks the third grant.
        clr_counts();
        o_tready = '0;
        send_pkt(0, 1, 100, 7);
        send_pkt(1, 1, -50, 33);
        send_pkt(2, 1, 5, -200);
        tick(20);
        check("t3_grants_while_full", 64'(glog_ch.size()), 64'd2);
        check("t3_busy_while_full", 64'(busy), 64'd0);
        check("t3_i_tready_while_full", 64'(i_tready), 64'd0);
        check("t3_pending_results", 64'(sb.size()), 64'd3);
        o_tready = '1;
        wait_drain("t3_drain", 200);
        check("t3_grants_after_drain", 64'(glog_ch.size()), 64'd3);
        if (glog_ch.size() == 3) check("t3_third_grant_ch", 64'(glog_ch[2]), 64'd2);

        // Channel 1 then channel 3 with a randomly stalling engine input.
        clr_counts();
        rnd_rdy = 1'b1;
        send_pkt(1, 3, -300, 120);
        wait_grant("t4_grant1", 1, 50);
        send_pkt(3, 2, 77, -1000);
        wait_drain("t4_drain", 400);
        rnd_rdy = 1'b0;
        check("t4_lane1_count", 64'(lane_cnt[1]), 64'd3);
        check("t4_lane3_count", 64'(lane_cnt[3]), 64'd2);
        check("t4_grant_count", 64'(glog_ch.size()), 64'd2);

        // Clear in the middle of a channel 0 packet.
        clr_counts();
        send_pkt(0, 4, 11, 22);
        wait_grant("t5_grant0", 0, 50);
        tick(1);
        clear = 1'b1;
        src_q[0].delete();
        sb.delete();
        tick(1);
        clear = 1'b0;
        check_idle_outputs("t5_after_clear");
        tick(1);
        clr_counts();
        send_pkt(0, 1, 40, 9);
        send_pkt(1, 1, -9, 40);
        wait_drain("t5_drain", 200);
        check("t5_grant_count", 64'(glog_ch.size()), 64'd2);
        if (glog_ch.size() > 0) check("t5_first_grant_after_clear", 64'(glog_ch[0]), 64'd0);

        // Asynchronous reset mid-transfer.
        clr_counts();
        send_pkt(2, 4, 1234, -567);
        wait_grant("t6_grant2", 2, 50);
        tick(1);
        check("t6_eng_i_tvalid_before", 64'(eng_i_tvalid), 64'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("t6_async_reset");
        for (int c = 0; c < NCH; c++) src_q[c].delete();
        sb.delete();
        tick(2);
        reset_n = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
